// File: rtl/gate_array_sweeper_pkg.sv
// Shared encodings for the gate array: op select codes, sweep FSM states
// and the single-bit gate evaluation used by every channel slice.
package gate_array_sweeper_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'b00;
  localparam op_t OP_OR   = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_NAND = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Sweep covers the four (a, b) combinations; vector 3 is the final one
  localparam logic [1:0] VEC_LAST = 2'd3;

  function automatic logic gate_eval(input op_t op, input logic x, input logic y);
    logic res;
    case (op)
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_XOR:  res = x ^ y;
      default: res = ~(x & y);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_array_sweeper_if.sv
// Operand/control and result bundle between the lab top-level (SW/KEY side)
// and the gate array sweeper.
interface gate_array_sweeper_if #(
  parameter int CHANNELS = 4
);
  import gate_array_sweeper_pkg::*;

  op_t                 mode;
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;
  logic                in_valid;
  logic                sweep_en;
  logic [CHANNELS-1:0] out;
  logic                out_valid;
  logic                sweep_a;
  logic                sweep_b;
  logic                sweep_busy;
  logic                sweep_done;

  modport master (
    output mode, a, b, in_valid, sweep_en,
    input  out, out_valid, sweep_a, sweep_b, sweep_busy, sweep_done
  );

  modport slave (
    input  mode, a, b, in_valid, sweep_en,
    output out, out_valid, sweep_a, sweep_b, sweep_busy, sweep_done
  );

endinterface

// File: rtl/gate_array_sweeper_gate_op_slice.sv
// One combinational 2-input gate channel with run-time op select.
module gate_op_slice
  import gate_array_sweeper_pkg::*;
(
  input  op_t  i_mode,
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = gate_eval(i_mode, i_a, i_b);

endmodule

// File: rtl/gate_array_sweeper.sv
// CHANNELS-wide 2-input gate array with a registered result/valid and a
// truth-table sweep sequencer that walks (a,b) = 00,10,01,11 at STEP_CYCLES.
module gate_array_sweeper
  import gate_array_sweeper_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int STEP_CYCLES = 50000000
) (
  input  logic                 clock,
  input  logic                 reset,
  gate_array_sweeper_if.slave  bus
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  logic [1:0]          r_state;
  logic [1:0]          r_vec;
  logic [STEP_W-1:0]   r_step;
  logic                r_sweep_en_q;
  logic [CHANNELS-1:0] r_out_p1;
  logic                r_vld_p1;

  logic                w_rise;
  logic                w_start;
  logic                w_step_last;
  logic                w_apply_norm;
  logic                w_apply_sweep;
  logic                w_apply;
  logic [CHANNELS-1:0] w_a_eff;
  logic [CHANNELS-1:0] w_b_eff;
  logic [CHANNELS-1:0] w_result;

  assign w_rise      = bus.sweep_en & ~r_sweep_en_q;
  assign w_start     = (r_state == ST_IDLE) && w_rise;
  assign w_step_last = (r_step == STEP_LAST);

  // A sweep start outranks a coincident in_valid; a dropped sweep_en in RUN
  // suppresses the vector apply so out holds across an abort.
  assign w_apply_norm  = (r_state == ST_IDLE) && bus.in_valid && !w_rise;
  assign w_apply_sweep = (r_state == ST_RUN) && bus.sweep_en && (r_step == '0);
  assign w_apply       = w_apply_norm | w_apply_sweep;

  assign w_a_eff = w_apply_sweep ? {CHANNELS{r_vec[0]}} : bus.a;
  assign w_b_eff = w_apply_sweep ? {CHANNELS{r_vec[1]}} : bus.b;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    gate_op_slice u_slice (
      .i_mode (bus.mode),
      .i_a    (w_a_eff[gi]),
      .i_b    (w_b_eff[gi]),
      .o_y    (w_result[gi])
    );
  end

  // Stage p0 -> p1: gate results and valid strobe registered together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_apply;
      if (w_apply) r_out_p1 <= w_result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_vec        <= '0;
      r_step       <= '0;
      r_sweep_en_q <= 1'b0;
    end else begin
      r_sweep_en_q <= bus.sweep_en;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_vec   <= '0;
            r_step  <= '0;
          end
        end
        ST_RUN: begin
          if (!bus.sweep_en) begin
            r_state <= ST_IDLE;
          end else if (w_step_last) begin
            r_step <= '0;
            // vec stays on the last vector so sweep_a/b hold it through DONE
            if (r_vec == VEC_LAST) r_state <= ST_DONE;
            else                   r_vec   <= r_vec + 2'd1;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out        = r_out_p1;
  assign bus.out_valid  = r_vld_p1;
  assign bus.sweep_a    = r_vec[0];
  assign bus.sweep_b    = r_vec[1];
  assign bus.sweep_busy = (r_state == ST_RUN);
  assign bus.sweep_done = (r_state == ST_DONE);

endmodule
